// File: rtl/btn_reader.sv
// Debounced push-button reader: per-channel synchroniser, debounce filter and
// press/hold FSM producing a clean level plus press/release/long/repeat pulses.
module btn_reader #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned DEB_CYCLES    = 500000,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] BTN,
  output logic [N_BTN-1:0] LEVEL,
  output logic [N_BTN-1:0] PRESS,
  output logic [N_BTN-1:0] RELEASE,
  output logic [N_BTN-1:0] LONG,
  output logic [N_BTN-1:0] REPEAT
);

  localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam int unsigned REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int unsigned HOLD_W = (LONG_W > REP_W) ? LONG_W : REP_W;

  localparam logic [DEB_W-1:0]  DEB_TERM  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_TERM = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_TERM  = HOLD_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    UP        = 2'd0,
    DOWN      = 2'd1,
    DOWN_LONG = 2'd2
  } state_e;

  logic [N_BTN-1:0]  sync1_q, sync1_d;
  logic [N_BTN-1:0]  sync2_q, sync2_d;
  logic [N_BTN-1:0]  level_q, level_d;
  logic [N_BTN-1:0]  press_q, press_d;
  logic [N_BTN-1:0]  rel_q, rel_d;
  logic [N_BTN-1:0]  long_q, long_d;
  logic [N_BTN-1:0]  rpt_q, rpt_d;
  logic [N_BTN-1:0]  accept_c;
  logic [DEB_W-1:0]  deb_q  [N_BTN];
  logic [DEB_W-1:0]  deb_d  [N_BTN];
  logic [HOLD_W-1:0] hold_q [N_BTN];
  logic [HOLD_W-1:0] hold_d [N_BTN];
  state_e            state_q [N_BTN];
  state_e            state_d [N_BTN];

  // Next-state logic for all channels; each channel only touches its own bits.
  always_comb begin
    sync1_d  = BTN;
    sync2_d  = sync1_q;
    level_d  = level_q;
    press_d  = '0;
    rel_d    = '0;
    long_d   = '0;
    rpt_d    = '0;
    accept_c = '0;
    for (int i = 0; i < N_BTN; i++) begin
      deb_d[i]   = deb_q[i];
      hold_d[i]  = hold_q[i];
      state_d[i] = state_q[i];

      // Debounce: a level change is accepted only after an unbroken run.
      if (sync2_q[i] != level_q[i]) begin
        if (deb_q[i] == DEB_TERM) begin
          accept_c[i] = 1'b1;
          level_d[i]  = ~level_q[i];
          deb_d[i]    = '0;
        end else if (deb_q[i] != '1) begin
          deb_d[i] = deb_q[i] + DEB_W'(1);
        end
      end else begin
        deb_d[i] = '0;
      end

      case (state_q[i])
        UP: begin
          hold_d[i] = '0;
          if (accept_c[i] && !level_q[i]) begin
            state_d[i] = DOWN;
            press_d[i] = 1'b1;
          end
        end
        DOWN: begin
          if (accept_c[i] && level_q[i]) begin
            state_d[i] = UP;
            rel_d[i]   = 1'b1;
            hold_d[i]  = '0;
          end else if (hold_q[i] == LONG_TERM) begin
            state_d[i] = DOWN_LONG;
            long_d[i]  = 1'b1;
            hold_d[i]  = '0;
          end else if (hold_q[i] != '1) begin
            hold_d[i] = hold_q[i] + HOLD_W'(1);
          end
        end
        DOWN_LONG: begin
          if (accept_c[i] && level_q[i]) begin
            state_d[i] = UP;
            rel_d[i]   = 1'b1;
            hold_d[i]  = '0;
          end else if (hold_q[i] == REP_TERM) begin
            rpt_d[i]  = 1'b1;
            hold_d[i] = '0;
          end else if (hold_q[i] != '1) begin
            hold_d[i] = hold_q[i] + HOLD_W'(1);
          end
        end
        default: begin
          state_d[i] = UP;
          hold_d[i]  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      rpt_q   <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        deb_q[i]   <= '0;
        hold_q[i]  <= '0;
        state_q[i] <= UP;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
      for (int i = 0; i < N_BTN; i++) begin
        deb_q[i]   <= deb_d[i];
        hold_q[i]  <= hold_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign LEVEL   = level_q;
  assign PRESS   = press_q;
  assign RELEASE = rel_q;
  assign LONG    = long_q;
  assign REPEAT  = rpt_q;

endmodule

// File: tb/tb_btn_reader.sv
// Directed vector bench for btn_reader with small debounce/hold parameters.
module tb_btn_reader;

  localparam int unsigned N = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] level, press, rel, lng, rpt;

  btn_reader #(
    .N_BTN(N), .DEB_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8)
  ) dut (
    .CLK(clk), .RST(rst), .BTN(btn),
    .LEVEL(level), .PRESS(press), .RELEASE(rel), .LONG(lng), .REPEAT(rpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] b;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rls;
    logic [3:0] lg;
    logic [3:0] rp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add_n(input int n, input logic [3:0] b, input logic [3:0] lvl,
                       input logic [3:0] prs, input logic [3:0] rls,
                       input logic [3:0] lg, input logic [3:0] rp);
    vec_t v;
    v.b = b; v.lvl = lvl; v.prs = prs; v.rls = rls; v.lg = lg; v.rp = rp;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] lvl,
                       input logic [3:0] prs, input logic [3:0] rls,
                       input logic [3:0] lg, input logic [3:0] rp);
    logic [19:0] got, exp;
    got = {level, press, rel, lng, rpt};
    exp = {lvl, prs, rls, lg, rp};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got lvl/prs/rel/long/rpt=%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b",
               name, idx, level, press, rel, lng, rpt, lvl, prs, rls, lg, rp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    btn = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;

    // Clean press/release on channel 0
    add_n(5,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(1,  4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add_n(4,  4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(5,  4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(1,  4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    add_n(2,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Bouncing press on channel 1: 1,0,1,1,0,1,1,1,1 then held
    add_n(1,  4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(1,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(2,  4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(1,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(5,  4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(1,  4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    add_n(1,  4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(5,  4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(1,  4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    add_n(1,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // A lone 3-cycle glitch must be filtered out
    add_n(3,  4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(6,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Long press and auto-repeat on channel 2
    add_n(5,  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(1,  4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    add_n(19, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(1,  4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    for (int r = 0; r < 3; r++) begin
      add_n(7, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add_n(1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    end
    add_n(1,  4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(5,  4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(1,  4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    add_n(10, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Channel 3 fall accepted exactly when the hold count reaches LONG-1
    add_n(5,  4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(1,  4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    add_n(14, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(5,  4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(1,  4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    add_n(5,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Simultaneous press/release on channels 0 and 3
    add_n(5,  4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(1,  4'b1001, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    add_n(2,  4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(5,  4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_n(1,  4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
    add_n(2,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      btn = vecs[i].b;
      step();
      check("table", i, vecs[i].lvl, vecs[i].prs, vecs[i].rls, vecs[i].lg, vecs[i].rp);
    end

    // Reset in the middle of a held press on channel 0
    btn = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step();
      check("pre_rst", k, (k >= 5) ? 4'b0001 : 4'b0000, (k == 5) ? 4'b0001 : 4'b0000,
            4'h0, 4'h0, 4'h0);
    end
    rst = 1'b1;
    #1;
    check("rst_async", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst_held", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("post_rst", k, (k >= 5) ? 4'b0001 : 4'b0000, (k == 5) ? 4'b0001 : 4'b0000,
            4'h0, 4'h0, 4'h0);
    end
    btn = 4'b0000;
    for (int k = 0; k < 7; k++) begin
      step();
      check("post_rst_rel", k, (k < 5) ? 4'b0001 : 4'b0000, 4'h0,
            (k == 5) ? 4'b0001 : 4'b0000, 4'h0, 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_reader.md
# btn_reader

Debounced push-button input block for the Basys board: the input-side counterpart of the 7-segment display drivers. It takes the raw, asynchronous, bouncing BTN pins, synchronises and debounces each one independently, and produces a clean level plus single-cycle event pulses for press, release, long-press and auto-repeat. Display and control logic consume these pulses instead of raw button levels.

## Interface
- N_BTN, 4, number of independent button channels
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be ≥1
- LONG_CYCLES, 50000000, held cycles after the accepted press before LONG fires (1 s at 50 MHz); must be ≥1
- REPEAT_CYCLES, 10000000, period of REPEAT pulses after LONG while still held; must be ≥1

Ports:
- CLK  input  1  single system clock; all state updates on its rising edge
- RST  input  1  asynchronous, active-high reset
- BTN  input  N_BTN  raw button pins, asynchronous to CLK, active-high
- LEVEL  output  N_BTN  debounced button state, registered
- PRESS  output  N_BTN  one-cycle pulse when LEVEL rises
- RELEASE  output  N_BTN  one-cycle pulse when LEVEL falls
- LONG  output  N_BTN  one-cycle pulse when a press has been held LONG_CYCLES
- REPEAT  output  N_BTN  one-cycle pulse every REPEAT_CYCLES after LONG while held

## Operation
- Per channel: 2-flop synchroniser (sync1→sync2), debounce counter, hold counter, and a 3-state FSM: UP, DOWN, DOWN_LONG.
- Debounce: each cycle, if sync2 ≠ LEVEL the debounce counter increments; if sync2 = LEVEL it clears to 0. When sync2 ≠ LEVEL and the counter is DEB_CYCLES-1, LEVEL toggles and the counter clears. Any glitch shorter than DEB_CYCLES therefore restarts the count.
- UP→DOWN on accepted rise: PRESS=1 for that cycle, hold counter cleared.
- DOWN: hold counter increments each cycle. At LONG_CYCLES-1, LONG=1 for one cycle, hold counter cleared, →DOWN_LONG.
- DOWN_LONG: hold counter increments. At REPEAT_CYCLES-1, REPEAT=1 for one cycle, counter cleared, stay.
- DOWN or DOWN_LONG → UP on accepted fall: RELEASE=1 for that cycle. LONG and REPEAT are suppressed on the release cycle, even if the hold counter hits its terminal value on that same cycle.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses on the same cycle.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. Counters saturate, never wrap.

## Timing
- Reset value of every output and internal register is 0; all FSMs are in UP.
- RST mid-press: everything clears. If BTN is still held after RST deasserts, the input is re-debounced from zero and a fresh PRESS is produced. No RELEASE is produced for the press interrupted by reset.
- Press latency: BTN is first captured high by sync1 at edge 0 and stays high. LEVEL rises and PRESS pulses in the cycle following edge DEB_CYCLES+1.
- Release latency: same rule, applied to the falling input.
- LONG fires LONG_CYCLES edges after the PRESS edge.
- The first REPEAT fires REPEAT_CYCLES edges after the LONG edge, then every REPEAT_CYCLES edges after that.
- All outputs are registered. Every pulse is exactly one CLK cycle wide.

## Test plan
Bench parameters: DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, N_BTN=4.

- Clean press: BTN[0] rises and is held 10 cycles → PRESS[0] pulses once, 5 edges after capture. LEVEL[0]=1. No other channel changes.
- Bounce: BTN[1] toggles 1,0,1,1,0,1,1,1,1 → PRESS[1] only after 4 consecutive synced highs; exactly one PRESS. A 3-cycle glitch alone produces no PRESS.
- Long and repeat: hold BTN[2] for 50 cycles after PRESS → LONG at PRESS+20, REPEAT at +28, +36, +44. Release gives one RELEASE and no further REPEAT.
- Release on terminal count: release BTN[3] so the accepted fall lands exactly on hold count 19 → RELEASE only, no LONG.
- Reset mid-hold: assert RST while LEVEL[0]=1 and BTN held → all outputs 0 immediately. After deassert, PRESS[0] is re-issued 5 edges later, with no RELEASE.
- Simultaneous: BTN[0] and BTN[3] rise on the same cycle → PRESS=4'b1001 on a single cycle.
